cs_census: RTL and testbench
============================

Name: cs_census

Overview:
- Streaming center-symmetric census transform (CSCT) for the stereo matching core.
- Consumes a raster-order pixel stream and builds a WC x WC window from internal line buffers.
- Emits one (WC^2)/2-bit signature per interior pixel: the bit-vector that downstream XOR + popcount (num_ones) consumes.
- Instantiated once per camera channel, ahead of the Hamming-cost stage.

Parameters:
- WC, 7, census window size (odd, >=3).
- DW, 8, pixel bit width.
- IMG_W, 640, pixels per line (> WC).
- IMG_H, 480, lines per frame (> WC).
- NOBIT (localparam), (WC**2)/2, signature width; must equal NIBIT of num_ones for the same WC.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_pixel  in  DW  input pixel, raster order.
- i_dval  in  1  i_pixel valid; a beat is accepted on each rising edge with i_dval=1.
- o_dval  out  1  o_data valid, one-cycle pulse per signature.
- o_data  out  NOBIT  CSCT signature.

Behaviour:
- Reset (async, i_rstn=0): col counter=0, row counter=0, window regs=0, o_dval=0, o_data=0. Line-buffer RAM is not reset.
  - Output gating (below) guarantees stale RAM contents never reach o_data.
- Line buffers: WC-1 delay lines of depth IMG_W, one DW word per entry.
  - On each accepted beat, column c receives i_pixel plus the previous WC-1 lines' pixels at column c.
- Window: WC x WC register array, indexed row-major p = 0..WC*WC-1, oldest line/leftmost column = p0.
  - Each accepted beat shifts the window left by one column and loads the new column at the right.
- Signature: bit k (k = 0..NOBIT-1) = (win[k] > win[WC*WC-1-k]), unsigned compare.
  - The center pixel, p = (WC*WC-1)/2, is unused.
- Counters: col increments per accepted beat and wraps IMG_W-1 -> 0. On that wrap, row increments; row wraps IMG_H-1 -> 0 (next frame).
- o_dval=1 in the cycle after an accepted beat whose pre-increment counters satisfy row >= WC-1 and col >= WC-1. Otherwise o_dval=0.
  - The signature corresponds to image pixel (row-(WC-1)/2, col-(WC-1)/2).
  - Latency is 1 clock from the accepted beat.
  - Outputs per frame: (IMG_H-WC+1)*(IMG_W-WC+1).
- o_data updates only together with o_dval=1 and holds otherwise.
- Stall: i_dval=0 freezes counters, line buffers and window; o_dval=0 the next cycle. Arbitrary i_dval gaps, including mid-line, produce output identical to an unstalled stream.
- Line wrap: the window still holds columns from the previous line for the first WC-1 beats of a new line. The col >= WC-1 gating suppresses those outputs.
- Frame wrap: the first WC-1 lines of a new frame produce no output. Line-buffer contents from the previous frame are overwritten before use.
- Reset mid-frame: everything above returns to its reset values immediately. The next accepted pixel is treated as (row 0, col 0).
- No backpressure input; downstream must accept every o_dval pulse.

Optional Feature:
- Macro CS_CENSUS_SOF_EN.
- Defined: adds input port i_sof (1 bit, qualified by i_dval).
  - An accepted beat with i_sof=1 is forced to (row 0, col 0); counters then advance from there.
  - No output is produced for that beat; o_dval=0 in the following cycle.
  - Resynchronises after a dropped or partial frame.
- Not defined: port absent; framing is purely by counting IMG_W x IMG_H beats from reset.

Test Plan:
Unless noted, tests use WC=3, DW=8, IMG_W=4, IMG_H=4, so NOBIT=4.
- Constant image (all pixels 0x55), continuous i_dval -> exactly 4 o_dval pulses per frame, each with o_data=4'b0000. The first pulse comes the cycle after the 11th beat (row 2, col 2).
- Ascending ramp, pixel = row*4+col -> 4 pulses, all o_data=4'b0000. Descending ramp, pixel = 255-(row*4+col) -> 4 pulses, all o_data=4'b1111.
- Same descending ramp with i_dval toggled 1,0,0,1,... -> same 4 signatures in the same order. o_dval never asserts in a cycle following i_dval=0.
- Two back-to-back frames with different content -> 4 pulses per frame. The second frame's signatures depend only on second-frame pixels; no outputs during its rows 0-1.
- Assert i_rstn=0 after 7 beats, release, then send a full frame -> o_dval=0 and o_data=0 during reset. The full frame yields exactly 4 correct pulses.
- With CS_CENSUS_SOF_EN: send 6 beats, then a new frame starting with i_sof=1 -> behaves exactly as a fresh frame after reset (4 pulses, correct values).

Source files
------------

// File: rtl/cs_census.sv
// -----------------------------------------------------------------------------
// cs_census : streaming center-symmetric census transform (CSCT)
//
// Takes a raster-order pixel stream and keeps the last WC-1 lines in internal
// line buffers. From them it builds a WC x WC window and emits one
// (WC*WC)/2-bit signature per interior pixel. That signature is the bit-vector
// the downstream XOR + popcount stage consumes.
//
// Optional feature (compile-time macro CS_CENSUS_SOF_EN):
//   When defined, the block gains input i_sof. An accepted beat with i_sof=1
//   is taken as (row 0, col 0) of a new frame, which resynchronises framing
//   after a dropped or partial frame. When not defined, framing comes purely
//   from counting IMG_W x IMG_H beats from reset.
//
// Parameters:
//   WC     census window size (odd, >= 3)
//   DW     pixel bit width
//   IMG_W  pixels per line (> WC)
//   IMG_H  lines per frame (> WC)
//
// Ports:
//   i_clk    in   1            clock, all state on rising edge
//   i_rstn   in   1            asynchronous active-low reset
//   i_pixel  in   DW           input pixel, raster order
//   i_dval   in   1            i_pixel valid; one beat accepted per high edge
//   i_sof    in   1            start of frame (only with CS_CENSUS_SOF_EN)
//   o_dval   out  1            one-cycle pulse per signature
//   o_data   out  (WC*WC)/2    CSCT signature, held between pulses
// -----------------------------------------------------------------------------
module cs_census #(
    parameter int WC    = 7,
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [DW-1:0]          i_pixel,
    input  logic                   i_dval,
`ifdef CS_CENSUS_SOF_EN
    input  logic                   i_sof,
`endif
    output logic                   o_dval,
    output logic [(WC*WC)/2-1:0]   o_data
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int NOBIT = (WC * WC) / 2;
    localparam int NPIX  = WC * WC;
    localparam int NLB   = WC - 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WC - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WC - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [DW-1:0]    win_r [NPIX];           // row-major, p0 = oldest/leftmost
    logic [DW-1:0]    lb_r  [NLB][IMG_W];     // lb_r[0] = previous line
    logic             dval_r;
    logic [NOBIT-1:0] data_r;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             beat_s;
    logic             sof_s;
    logic [COL_W-1:0] col_eff_s;
    logic [ROW_W-1:0] row_eff_s;
    logic [COL_W-1:0] col_next_s;
    logic [ROW_W-1:0] row_next_s;
    logic             out_ok_s;
    logic [DW-1:0]    col_pix_s [WC];         // incoming column, top = oldest
    logic [DW-1:0]    win_next_s [NPIX];
    logic [NOBIT-1:0] sig_s;

    assign beat_s = i_dval;

`ifdef CS_CENSUS_SOF_EN
    assign sof_s = i_sof;
`else
    assign sof_s = 1'b0;
`endif

    // Effective position of the current beat (a start-of-frame forces 0,0)
    always_comb begin
        col_eff_s = col_r;
        row_eff_s = row_r;
        if (sof_s) begin
            col_eff_s = COL_ZERO;
            row_eff_s = ROW_ZERO;
        end else begin
            col_eff_s = col_r;
            row_eff_s = row_r;
        end
    end

    // Next raster position: column wraps at line end, row wraps at frame end
    always_comb begin
        col_next_s = col_eff_s;
        row_next_s = row_eff_s;
        if (col_eff_s == COL_LAST) begin
            col_next_s = COL_ZERO;
            if (row_eff_s == ROW_LAST) begin
                row_next_s = ROW_ZERO;
            end else begin
                row_next_s = row_eff_s + ROW_ONE;
            end
        end else begin
            col_next_s = col_eff_s + COL_ONE;
            row_next_s = row_eff_s;
        end
    end

    // A signature is only valid once the window lies fully inside the image;
    // this also hides stale line-buffer data and previous-line columns.
    always_comb begin
        out_ok_s = 1'b0;
        if ((row_eff_s >= ROW_MIN) && (col_eff_s >= COL_MIN)) begin
            out_ok_s = 1'b1;
        end else begin
            out_ok_s = 1'b0;
        end
    end

    // Assemble the new column: WC-1 buffered lines plus the live pixel
    always_comb begin
        for (int r = 0; r < WC; r++) begin
            col_pix_s[r] = '0;
        end
        for (int r = 0; r < NLB; r++) begin
            col_pix_s[r] = lb_r[NLB-1-r][col_eff_s];
        end
        col_pix_s[WC-1] = i_pixel;
    end

    // Window after this beat: shift left one column, new column on the right
    always_comb begin
        for (int p = 0; p < NPIX; p++) begin
            if ((p % WC) == (WC - 1)) begin
                win_next_s[p] = col_pix_s[p / WC];
            end else begin
                win_next_s[p] = win_r[p + 1];
            end
        end
    end

    // Center-symmetric compares over the post-shift window (center unused)
    always_comb begin
        sig_s = '0;
        for (int k = 0; k < NOBIT; k++) begin
            sig_s[k] = (win_next_s[k] > win_next_s[NPIX-1-k]);
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Line-buffer RAM: delay lines cascaded per column, not reset
    always_ff @(posedge i_clk) begin
        if (beat_s) begin
            lb_r[0][col_eff_s] <= i_pixel;
            for (int j = 1; j < NLB; j++) begin
                lb_r[j][col_eff_s] <= lb_r[j-1][col_eff_s];
            end
        end
    end

    // Raster counters advance only on accepted beats
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (beat_s) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
        end
    end

    // Window register array
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int p = 0; p < NPIX; p++) begin
                win_r[p] <= '0;
            end
        end else if (beat_s) begin
            for (int p = 0; p < NPIX; p++) begin
                win_r[p] <= win_next_s[p];
            end
        end
    end

    // Output strobe: one pulse per accepted beat with a full window
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dval_r <= 1'b0;
        end else begin
            dval_r <= beat_s & out_ok_s;
        end
    end

    // Output data: loaded with the strobe, held otherwise
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_r <= '0;
        end else if (beat_s && out_ok_s) begin
            data_r <= sig_s;
        end
    end

    assign o_dval = dval_r;
    assign o_data = data_r;

endmodule

// File: tb/tb_cs_census.sv
module tb_cs_census;

    localparam int WC    = 3;
    localparam int DW    = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int NOBIT = (WC * WC) / 2;
    localparam int NEXP  = (IMG_H - WC + 1) * (IMG_W - WC + 1);
    localparam int FIRST = (WC - 1) * IMG_W + WC;

    logic             clk = 1'b0;
    logic             rstn;
    logic [DW-1:0]    pixel;
    logic             dval;
    logic             sof;
    logic             o_dval;
    logic [NOBIT-1:0] o_data;

    int errors = 0;
    int checks = 0;

    // reference model state
    int               m_row;
    int               m_col;
    logic [DW-1:0]    img [IMG_H][IMG_W];
    logic             m_dval;
    logic [NOBIT-1:0] m_data;

    always #5 clk = ~clk;

    cs_census #(.WC(WC), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_pixel (pixel),
        .i_dval  (dval),
`ifdef CS_CENSUS_SOF_EN
        .i_sof   (sof),
`endif
        .o_dval  (o_dval),
        .o_data  (o_data)
    );

    // signature of the WC x WC image patch whose bottom-right corner is (r,c)
    function automatic logic [NOBIT-1:0] sig_at(int r, int c);
        logic [DW-1:0]    w [WC*WC];
        logic [NOBIT-1:0] s;
        for (int dr = 0; dr < WC; dr++)
            for (int dc = 0; dc < WC; dc++)
                w[dr*WC+dc] = img[r-WC+1+dr][c-WC+1+dc];
        s = '0;
        for (int k = 0; k < NOBIT; k++)
            s[k] = (w[k] > w[WC*WC-1-k]);
        return s;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs, advance the model, check outputs after the edge
    task automatic step(logic [DW-1:0] p, bit v, bit s);
        @(negedge clk);
        pixel = p;
        dval  = v;
        sof   = s;
        m_dval = 1'b0;
        if (v) begin
`ifdef CS_CENSUS_SOF_EN
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
`endif
            img[m_row][m_col] = p;
            if (m_row >= WC - 1 && m_col >= WC - 1) begin
                m_dval = 1'b1;
                m_data = sig_at(m_row, m_col);
            end
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                m_row++;
                if (m_row == IMG_H) m_row = 0;
            end
        end
        @(posedge clk);
        #1;
        check("o_dval", o_dval, m_dval);
        check("o_data", o_data, m_data);
    endtask

    // kind: 0 const 0x55, 1 ascending ramp, 2 descending ramp, 3 random
    // gap : 0 none, 1 pattern 1,0,0, 2 random idle cycles
    task automatic frame(int kind, int gap, int cexp, bit sof_first);
        int beat;
        int first;
        int cnt;
        logic [DW-1:0] p;
        beat  = 0;
        first = -1;
        cnt   = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                case (kind)
                    0:       p = 8'h55;
                    1:       p = 8'(r * IMG_W + c);
                    2:       p = 8'(255 - (r * IMG_W + c));
                    default: p = 8'($urandom);
                endcase
                step(p, 1'b1, sof_first && r == 0 && c == 0);
                beat++;
                if (o_dval) begin
                    cnt++;
                    if (first < 0) first = beat;
                    if (cexp >= 0) check("const_sig", 32'(o_data), 32'(cexp));
                end
                if (gap == 1) begin
                    step(8'($urandom), 1'b0, 1'b0);
                    step(8'($urandom), 1'b0, 1'b0);
                end else if (gap == 2) begin
                    repeat ($urandom_range(0, 2)) step(8'($urandom), 1'b0, 1'b1);
                end
            end
        end
        check("pulses_per_frame", 32'(cnt), 32'(NEXP));
        check("first_pulse_beat", 32'(first), 32'(FIRST));
    endtask

    task automatic model_reset();
        m_row  = 0;
        m_col  = 0;
        m_dval = 1'b0;
        m_data = '0;
    endtask

    initial begin
        rstn  = 1'b0;
        dval  = 1'b0;
        sof   = 1'b0;
        pixel = '0;
        model_reset();
        #2;
        check("reset_dval", o_dval, 1'b0);
        check("reset_data", o_data, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // directed images
        frame(0, 0, 0, 1'b0);
        frame(1, 0, 0, 1'b0);
        frame(2, 0, 15, 1'b0);
        frame(2, 1, 15, 1'b0);

        // back-to-back random frames
        frame(3, 0, -1, 1'b0);
        frame(3, 0, -1, 1'b0);

        // reset mid-frame after 7 beats
        for (int i = 0; i < 7; i++) step(8'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        dval = 1'b0;
        model_reset();
        #1;
        check("midreset_dval", o_dval, 1'b0);
        check("midreset_data", o_data, '0);
        @(posedge clk);
        #1;
        check("midreset_dval2", o_dval, 1'b0);
        check("midreset_data2", o_data, '0);
        @(negedge clk);
        rstn = 1'b1;
        frame(3, 0, -1, 1'b0);

        // random frames with random stalls
        for (int f = 0; f < 4; f++) frame(3, 2, -1, 1'b0);

`ifdef CS_CENSUS_SOF_EN
        // partial frame, then resync with start-of-frame
        for (int i = 0; i < 6; i++) step(8'($urandom), 1'b1, 1'b0);
        frame(3, 0, -1, 1'b1);
        frame(2, 2, 15, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
